// File: rtl/mem_io_responder.sv
// Responder end of the CPU byte bus: byte RAM plus memory-mapped UART TX/RX FIFOs,
// a free-running cycle counter with a readable snapshot, and a sticky program-stop flag.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH       = 16,
  parameter int RX_DEPTH       = 16,
  parameter int TX_SLACK       = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_AW + 1;

  // Address decode: bits 17:16 == 2'b11 select IO, everything else is RAM.
  logic                      io_sel;
  logic [15:0]               io_off;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic                      unused_addr_bits;

  assign io_sel           = (cpu_a[17:16] == 2'b11);
  assign io_off           = cpu_a[15:0];
  assign ram_idx          = cpu_a[RAM_ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^cpu_a[31:18];

  logic io_rd_rx, io_rd_cnt, io_wr_tx, io_wr_stop;

  assign io_rd_rx   = io_sel && !cpu_wr && (io_off == 16'h0000);
  assign io_rd_cnt  = io_sel && !cpu_wr && (io_off == 16'h0004);
  assign io_wr_tx   = io_sel &&  cpu_wr && (io_off == 16'h0000) && (cpu_dout != 8'h00);
  assign io_wr_stop = io_sel &&  cpu_wr && (io_off == 16'h0004);

  // RAM: read-first; the result is only used on read cycles.
  logic [7:0] ram [0:(1<<RAM_ADDR_WIDTH)-1];
  logic [7:0] ram_q;

  always_ff @(posedge clk_in) begin
    if (cpu_wr && !io_sel) ram[ram_idx] <= cpu_dout;
    ram_q <= ram[ram_idx];
  end

  // Both FIFO ports use valid/ready: a byte moves on a clock edge where valid and
  // ready are both high; valid never waits on ready, and rx_ready never looks at rx_valid.
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_rd_ptr, tx_wr_ptr;
  logic [TX_CW-1:0] tx_count, tx_count_next;
  logic             tx_push_req, tx_push, tx_pop, tx_full;
  logic [7:0]       tx_push_data;

  assign tx_push_req   = io_wr_tx || io_wr_stop;
  assign tx_push_data  = io_wr_stop ? 8'h00 : cpu_dout;
  assign tx_valid      = (tx_count != '0);
  assign tx_data       = tx_mem[tx_rd_ptr];
  assign tx_pop        = tx_valid && tx_ready;
  assign tx_full       = (tx_count == TX_CW'(TX_DEPTH));
  assign tx_push       = tx_push_req && (!tx_full || tx_pop);
  assign tx_count_next = tx_count + TX_CW'(tx_push) - TX_CW'(tx_pop);

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_push_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_rd_ptr      <= '0;
      tx_wr_ptr      <= '0;
      tx_count       <= '0;
      io_buffer_full <= 1'b0;
      tx_overflow    <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_count       <= tx_count_next;
      io_buffer_full <= (tx_count_next >= TX_CW'(TX_DEPTH - TX_SLACK));
      if (tx_push_req && tx_full && !tx_pop) tx_overflow <= 1'b1;
    end
  end

  // RX FIFO: a CPU pop frees a slot in the same cycle, so a full FIFO still accepts.
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_rd_ptr, rx_wr_ptr;
  logic [RX_CW-1:0] rx_count;
  logic             rx_push, rx_pop, rx_empty;

  assign rx_empty = (rx_count == '0);
  assign rx_pop   = io_rd_rx && !rx_empty;
  assign rx_ready = (rx_count != RX_CW'(RX_DEPTH)) || rx_pop;
  assign rx_push  = rx_valid && rx_ready;

  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_count <= rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);
    end
  end

  // Cycle counter, snapshot (latched by reading its low byte) and stop flag.
  logic [31:0] counter, snapshot;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      counter      <= '0;
      snapshot     <= '0;
      program_stop <= 1'b0;
    end else begin
      counter <= counter + 32'd1;
      if (io_rd_cnt)  snapshot     <= counter;
      if (io_wr_stop) program_stop <= 1'b1;
    end
  end

  logic [7:0] io_rdata;

  always_comb begin
    io_rdata = 8'h00;
    if (io_sel && !cpu_wr) begin
      case (io_off)
        16'h0000: io_rdata = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
        16'h0004: io_rdata = counter[7:0];
        16'h0005: io_rdata = snapshot[15:8];
        16'h0006: io_rdata = snapshot[23:16];
        16'h0007: io_rdata = snapshot[31:24];
        default:  io_rdata = 8'h00;
      endcase
    end
  end

  // Write cycles and reset steer cpu_din to the IO path, whose register holds 0 then.
  logic       rd_io_q;
  logic [7:0] io_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_io_q <= 1'b1;
      io_q    <= 8'h00;
    end else begin
      rd_io_q <= io_sel || cpu_wr;
      io_q    <= io_rdata;
    end
  end

  assign cpu_din = rd_io_q ? io_q : ram_q;

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder end of the CPU's byte-wide memory bus: decodes the address the CPU drives and answers with RAM data or memory-mapped I/O.
- Contains a byte-addressed synchronous RAM, a UART TX byte FIFO that drives `io_buffer_full`, an RX byte FIFO, a free-running cycle counter, and a program-stop flag.
- Sits between the CPU top and the UART/host interface, in place of the board RAM+HCI.

Parameters:
- RAM_ADDR_WIDTH, 17, RAM byte-address width; RAM has 2^RAM_ADDR_WIDTH bytes (128KB).
- TX_DEPTH, 16, TX FIFO entries; power of 2, minimum 4.
- RX_DEPTH, 16, RX FIFO entries; power of 2, minimum 2.
- TX_SLACK, 2, `io_buffer_full` asserts when TX occupancy >= TX_DEPTH-TX_SLACK.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous, active-high reset
- cpu_a  in  32  CPU address; bits 17:0 decoded
- cpu_wr  in  1  1 = write, 0 = read
- cpu_dout  in  8  CPU write data
- cpu_din  out  8  read data to CPU, registered
- io_buffer_full  out  1  TX FIFO near full
- tx_data  out  8  TX FIFO head byte
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  UART consumes the head byte when tx_valid and tx_ready are both high
- rx_data  in  8  host input byte
- rx_valid  in  1  host byte present
- rx_ready  out  1  RX FIFO not full
- program_stop  out  1  sticky stop indication
- tx_overflow  out  1  sticky: a TX push was dropped

Behaviour:
- Interface: one clock, clk_in; rst_in is synchronous and active-high.
- Reset values:
  - cpu_din=0, tx_valid=0, rx_ready=1, io_buffer_full=0, program_stop=0, tx_overflow=0.
  - FIFOs empty, counter=0, snapshot=0.
  - RAM contents are not cleared.
- Decode:
  - io_sel = (cpu_a[17:16]==2'b11).
  - Otherwise RAM, indexed by cpu_a[RAM_ADDR_WIDTH-1:0].
  - Address bits above 17 are ignored.
  - Every cycle is a transaction; there is no idle encoding. CPU "idle" is a read, which must be side-effect free except at the pop/snapshot addresses below.
- Read latency: cpu_din is updated at the clock edge after the address is presented, for both RAM and IO. Writes complete at the sampling edge with no wait.
- RAM read returns the byte at the index. A read of an address written in the previous cycle returns the new byte.
- IO reads (result in cpu_din next edge):
  - 0x30000: if RX non-empty, return the head byte and pop it. If empty, return 0x00 and do not pop.
  - 0x30004: return counter[7:0] and latch snapshot <= counter (current pre-increment value).
  - 0x30005/6/7: return snapshot[15:8], [23:16], [31:24].
  - Any other IO address returns 0x00 with no side effect.
- IO writes:
  - 0x30000 with data != 0: push to TX.
  - 0x30000 with data 0x00: ignored.
  - 0x30004: push 0x00 to TX, and set program_stop at that edge; it stays 1 until reset.
  - Any other IO address: ignored.
- TX push while TX is full, with no simultaneous pop: byte dropped, tx_overflow set (sticky).
- Simultaneous TX push and pop while full: both happen; occupancy unchanged; no overflow.
- io_buffer_full is a registered function of occupancy after the edge (occupancy >= TX_DEPTH-TX_SLACK). This gives the CPU TX_SLACK cycles of slack.
- RX FIFO:
  - Push when rx_valid && rx_ready.
  - CPU pop and host push in the same cycle on an empty FIFO: CPU gets 0x00 and the pushed byte is retained.
  - Pop and push on a full FIFO: pop frees the slot, push is accepted, and rx_ready stays 1.
- Counter: 32-bit, +1 every cycle after reset, wraps 0xFFFFFFFF -> 0.
- FIFO pointers wrap modulo depth; occupancy counter is log2(depth)+1 bits.
- Reset asserted mid-operation: the FIFOs flush, including in-flight bytes. A pending read result is replaced by 0.

Test Plan:
- RAM: write 0x5A to 0x00123, then read 0x00123 in the next cycle -> cpu_din=0x5A one edge later. Read 0x20123 (aliases with RAM_ADDR_WIDTH=17) -> 0x5A.
- TX: with tx_ready=0, write 'A','B',0x00,'C' to 0x30000 -> tx_valid=1 and 3 entries queued. Raise tx_ready -> tx_data sequence 0x41,0x42,0x43, then tx_valid=0.
- TX full: tx_ready=0, write 16 nonzero bytes -> io_buffer_full=1 after the 14th write. tx_overflow=0 after the 16th write, =1 after a 17th. Drain -> exactly 16 bytes out, in order.
- RX: host pushes 0x31,0x32 -> reads of 0x30000 return 0x31, 0x32, then 0x00. With 16 bytes queued, rx_ready=0.
- Counter: 100 cycles after reset release, read 0x30004..0x30007 on consecutive cycles -> bytes {99,0,0,0}. Snapshot is unchanged by subsequent 0x30005 reads.
- Stop: write 0x30004 (any data) -> program_stop=1 next edge, and 0x00 appears on tx_data. Assert rst_in -> program_stop=0, tx_valid=0, cpu_din=0.
